alu_rr_sequencer: RTL



---
 rtl/alu_pkg.sv | 18 +
 rtl/alu_rr_sequencer_rr_arb2.sv | 27 ++
 rtl/alu_rr_sequencer.sv | 137 +++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU round-robin sequencer and its benches.
package alu_pkg;
   localparam int DATA_W = 4;
   localparam int MODE_W = 4;
   localparam int OUT_W  = 2 * DATA_W;

   localparam logic [MODE_W-1:0] IDLE_MODE = 4'b1111;

   localparam logic [MODE_W-1:0] MODE_ADD = 4'b0000;
   localparam logic [MODE_W-1:0] MODE_MUL = 4'b0001;
   localparam logic [MODE_W-1:0] MODE_SUB = 4'b0010;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } seq_state_t;
endpackage

// File: rtl/alu_rr_sequencer_rr_arb2.sv
// Two-input round-robin grant; the last winner loses a tie until the next update.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] i_req,
   input  logic       i_upd,
   output logic       o_gnt_id
);
   logic r_last;

   always_ff @(posedge clk) begin
      if (rst)
         r_last <= 1'b1;
      else if (i_upd)
         r_last <= o_gnt_id;
   end

   always_comb begin
      o_gnt_id = 1'b0;
      unique case (i_req)
         2'b01:   o_gnt_id = 1'b0;
         2'b10:   o_gnt_id = 1'b1;
         2'b11:   o_gnt_id = ~r_last;
         default: o_gnt_id = 1'b0;
      endcase
   end
endmodule

// File: rtl/alu_rr_sequencer.sv
// Time-shares one combinational ALU between two requesters: round-robin accept,
// hold operands for EXEC_CYCLES, capture the result and return it with the requester id.
//
// state | meaning
// IDLE  | waiting for a request; ALU parked on IDLE_MODE
// EXEC  | operand registers drive the ALU; counting settle cycles
// RESP  | result held on the response channel until rsp_ready
module alu_rr_sequencer
   import alu_pkg::*;
#(
   parameter int EXEC_CYCLES = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [1:0]          req_valid,
   output logic [1:0]          req_ready,
   input  logic [2*DATA_W-1:0] req_in1,
   input  logic [2*DATA_W-1:0] req_in2,
   input  logic [2*MODE_W-1:0] req_mode,
   output logic [DATA_W-1:0]   alu_in1,
   output logic [DATA_W-1:0]   alu_in2,
   output logic [MODE_W-1:0]   alu_mode,
   input  logic [OUT_W-1:0]    alu_out,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [OUT_W-1:0]    rsp_data,
   output logic                rsp_id,
   output logic [7:0]          op_count
);
   seq_state_t        r_state;
   seq_state_t        w_next;
   logic [DATA_W-1:0] r_in1;
   logic [DATA_W-1:0] r_in2;
   logic [MODE_W-1:0] r_mode;
   logic              r_id;
   logic [3:0]        r_cnt;
   logic              r_rsp_valid;
   logic [OUT_W-1:0]  r_rsp_data;
   logic              r_rsp_id;
   logic [7:0]        r_op_count;
   logic              w_gnt;
   logic              w_accept;
   logic              w_last;

   assign w_last    = (r_cnt == 4'(EXEC_CYCLES - 1));
   assign rsp_valid = r_rsp_valid;
   assign rsp_data  = r_rsp_data;
   assign rsp_id    = r_rsp_id;
   assign op_count  = r_op_count;

   rr_arb2 u_arb (
      .clk      (clk),
      .rst      (rst),
      .i_req    (req_valid),
      .i_upd    (w_accept),
      .o_gnt_id (w_gnt)
   );

   always_ff @(posedge clk) begin
      if (rst)
         r_state <= ST_IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      req_ready = 2'b00;
      w_accept  = 1'b0;
      alu_in1   = '0;
      alu_in2   = '0;
      alu_mode  = IDLE_MODE;
      unique case (r_state)
         ST_IDLE: begin
            if (|req_valid) begin
               req_ready[w_gnt] = 1'b1;
               w_accept         = 1'b1;
               w_next           = ST_EXEC;
            end
         end
         ST_EXEC: begin
            alu_in1  = r_in1;
            alu_in2  = r_in2;
            alu_mode = r_mode;
            if (w_last)
               w_next = ST_RESP;
         end
         ST_RESP: begin
            if (rsp_ready)
               w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_in1       <= '0;
         r_in2       <= '0;
         r_mode      <= '0;
         r_id        <= 1'b0;
         r_cnt       <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_data  <= '0;
         r_rsp_id    <= 1'b0;
         r_op_count  <= '0;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_in1  <= w_gnt ? req_in1[2*DATA_W-1:DATA_W] : req_in1[DATA_W-1:0];
                  r_in2  <= w_gnt ? req_in2[2*DATA_W-1:DATA_W] : req_in2[DATA_W-1:0];
                  r_mode <= w_gnt ? req_mode[2*MODE_W-1:MODE_W] : req_mode[MODE_W-1:0];
                  r_id   <= w_gnt;
                  r_cnt  <= '0;
               end
            end
            ST_EXEC: begin
               r_cnt <= r_cnt + 4'd1;
               // alu_out is sampled only on the final settle cycle
               if (w_last) begin
                  r_rsp_data  <= alu_out;
                  r_rsp_id    <= r_id;
                  r_rsp_valid <= 1'b1;
               end
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_op_count  <= r_op_count + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end
endmodule
